// File: rtl/ariane_pkg.sv
// ariane_pkg: register-index constants and the queue entry layout shared by
// multi_issue_queue, its interface and the busy-register tracker.
package ariane_pkg;

    localparam int unsigned REG_IDX_W    = 5;
    localparam int unsigned NR_REGS      = 1 << REG_IDX_W;
    // Widest payload an entry can carry; narrower payloads are zero-extended.
    localparam int unsigned ENTRY_DATA_W = 64;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef struct packed {
        logic [ENTRY_DATA_W-1:0] data;
        reg_idx_t                rd;
        reg_idx_t                rs1;
        reg_idx_t                rs2;
    } entry_t;

endpackage

// File: rtl/multi_issue_queue_if.sv
// multi_issue_queue_if: decode-side push lanes, issue-side pop lanes,
// writeback ports and occupancy status of the multi-issue queue.
// The slave modport is the queue itself; master is its environment.
interface multi_issue_queue_if #(
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned NR_WB    = 4
);
    import ariane_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [NR_PORTS-1:0]                 in_valid_i;
    logic [NR_PORTS-1:0][DATA_W-1:0]     in_data_i;
    logic [NR_PORTS-1:0][REG_IDX_W-1:0]  in_rd_i;
    logic [NR_PORTS-1:0][REG_IDX_W-1:0]  in_rs1_i;
    logic [NR_PORTS-1:0][REG_IDX_W-1:0]  in_rs2_i;
    logic [NR_PORTS-1:0]                 in_ready_o;

    logic [NR_PORTS-1:0]                 out_valid_o;
    logic [NR_PORTS-1:0][DATA_W-1:0]     out_data_o;
    logic [NR_PORTS-1:0][REG_IDX_W-1:0]  out_rd_o;
    logic [NR_PORTS-1:0]                 out_ack_i;

    logic [NR_WB-1:0]                    wb_valid_i;
    logic [NR_WB-1:0][REG_IDX_W-1:0]     wb_rd_i;

    logic [CNT_W-1:0]                    count_o;
    logic                                full_o;

    modport slave (
        input  in_valid_i, in_data_i, in_rd_i, in_rs1_i, in_rs2_i,
        input  out_ack_i, wb_valid_i, wb_rd_i,
        output in_ready_o, out_valid_o, out_data_o, out_rd_o,
        output count_o, full_o
    );

    modport master (
        output in_valid_i, in_data_i, in_rd_i, in_rs1_i, in_rs2_i,
        output out_ack_i, wb_valid_i, wb_rd_i,
        input  in_ready_o, out_valid_o, out_data_o, out_rd_o,
        input  count_o, full_o
    );

endinterface

// File: rtl/reg_busy_tracker.sv
// reg_busy_tracker: one busy bit per architectural register. Issued writes
// set a bit, writebacks clear it, and a set beats a clear in the same cycle.
// Only instantiated when MULTI_ISSUE_HAZARD_CHECK_EN is defined.
module reg_busy_tracker
    import ariane_pkg::*;
#(
    parameter int unsigned NR_SET = 2,
    parameter int unsigned NR_CLR = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NR_SET-1:0]                set_valid_i,
    input  logic [NR_SET-1:0][REG_IDX_W-1:0] set_rd_i,
    input  logic [NR_CLR-1:0]                clr_valid_i,
    input  logic [NR_CLR-1:0][REG_IDX_W-1:0] clr_rd_i,
    output logic [NR_REGS-1:0]               busy_o
);

    logic [NR_REGS-1:0] busy_q;
    logic [NR_REGS-1:0] busy_d;

    // Apply clears first and sets after, so a set wins; x0 can never be busy.
    always_comb begin
        busy_d = busy_q;
        for (int c = 0; c < NR_CLR; c++) begin
            if (clr_valid_i[c]) begin
                busy_d[clr_rd_i[c]] = 1'b0;
            end
        end
        for (int s = 0; s < NR_SET; s++) begin
            if (set_valid_i[s]) begin
                busy_d[set_rd_i[s]] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Busy register with synchronous clear on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/multi_issue_queue.sv
// multi_issue_queue: circular issue queue accepting up to NR_PORTS decoded
// instructions per cycle and issuing up to NR_PORTS in order from the head.
// Define MULTI_ISSUE_HAZARD_CHECK_EN to hold back entries whose registers are
// busy or collide with an older lane's destination; without it every entry
// issues as soon as it is present and writeback inputs are ignored.
module multi_issue_queue
    import ariane_pkg::*;
#(
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned NR_WB    = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    multi_issue_queue_if.slave bus
);

    localparam int unsigned      PTR_W   = $clog2(DEPTH);
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    entry_t              mem_q [DEPTH];
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [CNT_W-1:0]    freeSlots;
    logic [CNT_W-1:0]    pushCnt;
    logic [CNT_W-1:0]    popCnt;
    logic [NR_PORTS-1:0] inReady;
    logic [NR_PORTS-1:0] pushMask;
    logic [NR_PORTS-1:0] outValid;
    logic [NR_PORTS-1:0] popMask;
    logic [NR_PORTS-1:0] blocked;
    logic                pushChain;
    logic                popChain;
    logic                issueChain;
    entry_t              headEnt [NR_PORTS];

    // Readiness comes only from free space at cycle start, never from same-cycle pops.
    always_comb begin
        freeSlots = DEPTH_C - count_q;
        inReady   = '0;
        for (int k = 0; k < NR_PORTS; k++) begin
            inReady[k] = !rst_i && !flush_i && (freeSlots > CNT_W'(k));
        end
    end

    // Accept lanes as a contiguous prefix; the first invalid or unready lane ends it.
    always_comb begin
        pushMask  = '0;
        pushCnt   = '0;
        pushChain = 1'b1;
        for (int k = 0; k < NR_PORTS; k++) begin
            pushChain   = pushChain && bus.in_valid_i[k] && inReady[k];
            pushMask[k] = pushChain;
            if (pushChain) begin
                pushCnt = pushCnt + CNT_W'(1);
            end
        end
    end

    // Candidate issue entries are the NR_PORTS slots starting at the head.
    always_comb begin
        for (int k = 0; k < NR_PORTS; k++) begin
            headEnt[k] = mem_q[head_q + PTR_W'(k)];
        end
    end

`ifdef MULTI_ISSUE_HAZARD_CHECK_EN
    logic [NR_REGS-1:0]                busy;
    logic [NR_PORTS-1:0]               setValid;
    logic [NR_PORTS-1:0][REG_IDX_W-1:0] setRd;

    // Hold an entry while any of its registers is busy or matches an older lane's destination.
    always_comb begin
        blocked = '0;
        for (int k = 0; k < NR_PORTS; k++) begin
            blocked[k] = busy[headEnt[k].rs1] || busy[headEnt[k].rs2] || busy[headEnt[k].rd];
            for (int j = 0; j < k; j++) begin
                if ((headEnt[j].rd != '0) &&
                    ((headEnt[j].rd == headEnt[k].rs1) ||
                     (headEnt[j].rd == headEnt[k].rs2) ||
                     (headEnt[j].rd == headEnt[k].rd))) begin
                    blocked[k] = 1'b1;
                end
            end
        end
    end

    // Issued lanes that write a real register mark it busy from the next cycle on.
    always_comb begin
        setValid = '0;
        setRd    = '0;
        for (int k = 0; k < NR_PORTS; k++) begin
            setValid[k] = popMask[k] && (headEnt[k].rd != '0);
            setRd[k]    = headEnt[k].rd;
        end
    end

    reg_busy_tracker #(
        .NR_SET (NR_PORTS),
        .NR_CLR (NR_WB)
    ) busyTracker (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .set_valid_i (setValid),
        .set_rd_i    (setRd),
        .clr_valid_i (bus.wb_valid_i),
        .clr_rd_i    (bus.wb_rd_i),
        .busy_o      (busy)
    );
`else
    logic [2*REG_IDX_W-1:0]            unusedSrc;
    logic [NR_WB-1:0]                  unusedWbValid;
    logic [NR_WB-1:0][REG_IDX_W-1:0]   unusedWbRd;

    assign blocked       = '0;
    assign unusedWbValid = bus.wb_valid_i;
    assign unusedWbRd    = bus.wb_rd_i;

    // Source registers only matter for hazard checking, which is compiled out here.
    always_comb begin
        unusedSrc = '0;
        for (int k = 0; k < NR_PORTS; k++) begin
            unusedSrc = unusedSrc ^ {headEnt[k].rs1, headEnt[k].rs2};
        end
    end
`endif

    // Issue lanes form a prefix of present, hazard-free entries from the head.
    always_comb begin
        outValid   = '0;
        issueChain = !rst_i && !flush_i;
        for (int k = 0; k < NR_PORTS; k++) begin
            issueChain  = issueChain && (count_q > CNT_W'(k)) && !blocked[k];
            outValid[k] = issueChain;
        end
    end

    // Pop the prefix of lanes that are both valid and acknowledged.
    always_comb begin
        popMask  = '0;
        popCnt   = '0;
        popChain = 1'b1;
        for (int k = 0; k < NR_PORTS; k++) begin
            popChain   = popChain && outValid[k] && bus.out_ack_i[k];
            popMask[k] = popChain;
            if (popChain) begin
                popCnt = popCnt + CNT_W'(1);
            end
        end
    end

    // Advance pointers by this cycle's pushes and pops; a flush empties the queue.
    always_comb begin
        head_d  = head_q + PTR_W'(popCnt);
        tail_d  = tail_q + PTR_W'(pushCnt);
        count_d = count_q + pushCnt - popCnt;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Write accepted lanes into consecutive slots starting at the tail.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NR_PORTS; k++) begin
            if (pushMask[k]) begin
                mem_q[tail_q + PTR_W'(k)] <= '{data: ENTRY_DATA_W'(bus.in_data_i[k]),
                                              rd:   bus.in_rd_i[k],
                                              rs1:  bus.in_rs1_i[k],
                                              rs2:  bus.in_rs2_i[k]};
            end
        end
    end

    // Present head entries on the issue lanes regardless of validity.
    always_comb begin
        for (int k = 0; k < NR_PORTS; k++) begin
            bus.out_data_o[k] = headEnt[k].data[DATA_W-1:0];
            bus.out_rd_o[k]   = headEnt[k].rd;
        end
    end

    assign bus.in_ready_o  = inReady;
    assign bus.out_valid_o = outValid;
    assign bus.count_o     = count_q;
    assign bus.full_o      = (count_q == DEPTH_C);

endmodule

// File: doc/multi_issue_queue.md
MULTI_ISSUE_QUEUE -- requirements
Module: multi_issue_queue

Interface
REQ-001 Parameter NR_PORTS, default 2: issue/decode lanes per cycle; legal values 1..4.
REQ-002 Parameter DEPTH, default 8: queue entries; power of two; at least 2*NR_PORTS.
REQ-003 Parameter DATA_W, default 64: opaque payload width per entry.
REQ-004 Parameter NR_WB, default 4: writeback ports clearing busy registers.
REQ-005 Ports, clock and reset first:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  discard all unissued entries.
- in_valid_i  in  NR_PORTS  decode lane valid.
- in_data_i  in  NR_PORTS x DATA_W  payload.
- in_rd_i, in_rs1_i, in_rs2_i  in  NR_PORTS x 5  register indices.
- in_ready_o  out  NR_PORTS  lane accepted.
- out_valid_o  out  NR_PORTS  issue lane valid.
- out_data_o  out  NR_PORTS x DATA_W  issue payload.
- out_rd_o  out  NR_PORTS x 5  issue destination register.
- out_ack_i  in  NR_PORTS  functional unit took lane.
- wb_valid_i  in  NR_WB  writeback valid.
- wb_rd_i  in  NR_WB x 5  writeback register.
- count_o  out  clog2(DEPTH)+1  occupied entries.
- full_o  out  1  count_o == DEPTH.

Function
REQ-006 Storage SHALL be a circular buffer with head/tail pointers wrapping modulo DEPTH.
REQ-007 in_ready_o[k] SHALL be 1 iff the number of free entries at cycle start exceeds k; same-cycle pops SHALL NOT raise readiness.
REQ-008 Lanes SHALL be accepted as a contiguous prefix: lane k is pushed only if lanes 0..k are all valid and ready; a valid lane after an invalid lane SHALL be dropped and not acknowledged.
REQ-009 Pushed entries SHALL NOT be visible on outputs until the next cycle; there is no bypass.
REQ-010 out_valid_o[k] SHALL be 1 iff count_o > k, out_valid_o[k-1] is 1 (k>0), and the entry at head+k is hazard-free (REQ-013..015).
REQ-011 Pop count SHALL be the length of the prefix of lanes with out_valid_o & out_ack_i; an ack on an invalid lane, or after a gap, SHALL be ignored.
REQ-012 Push and pop in the same cycle SHALL both take effect; count_o(next) = count_o + pushed - popped.
REQ-013 A 32-bit busy vector SHALL mark registers with an issued, unretired write; x0 is never busy.
REQ-014 An entry SHALL be blocked if rs1, rs2 or rd is busy, or equals the nonzero rd of a lower output lane in the same cycle.
REQ-015 An acked lane with rd != 0 SHALL set busy[rd] next cycle; wb_valid_i SHALL clear busy[wb_rd_i]; set SHALL win over clear for the same register in the same cycle.
REQ-016 flush_i SHALL empty the queue (count 0, head = tail = 0) next cycle, ignore that cycle's pushes and pops, and leave the busy vector unchanged.
REQ-017 While flush_i is high, in_ready_o and out_valid_o SHALL be 0.

Reset
REQ-018 rst_i SHALL clear pointers, count_o, full_o, out_valid_o, in_ready_o and the busy vector, with precedence over flush_i.
REQ-019 The first cycle after reset SHALL have in_ready_o all ones and out_valid_o all zeros.

Configuration
REQ-020 Macro MULTI_ISSUE_HAZARD_CHECK_EN: when defined, REQ-013..015 apply; when undefined, the busy vector is not built, entries are never hazard-blocked, and wb_* inputs are ignored.

Structure
REQ-021 Package ariane_pkg SHALL hold the REG_IDX_W=5 constant and the entry typedef {data, rd, rs1, rs2}.
REQ-022 The busy vector SHALL be a sub-module reg_busy_tracker.

Verification
REQ-023 NR_PORTS=2, DEPTH=8: push 2 per cycle for 4 cycles with no acks -> count_o 8, full_o 1, in_ready_o 00 in cycle 5.
REQ-024 Full queue, ack both lanes with in_valid 11 -> in_ready_o stays 00 that cycle; next cycle count_o 6 and in_ready_o 11.
REQ-025 in_valid_i=10 (lane 1 only) -> nothing pushed, count_o unchanged.
REQ-026 Head entry rd=x5, next entry rs1=x5 -> out_valid_o=01; after ack, second entry blocked until wb_valid_i[0]=1 with wb_rd_i=5, then valid next cycle.
REQ-027 Wrap: 12 pushes and 10 pops, interleaved -> head = 2, payload order preserved.
REQ-028 flush_i with count_o 5 and busy[7] set -> count_o 0 next cycle, busy[7] still set; rst_i -> busy cleared.
